// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit unsigned subtractor (a - b), LSB first, start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic sub_bit(input logic x, input logic y, input logic bin);
        return x ^ y ^ bin;
    endfunction

    function automatic logic sub_borrow(input logic x, input logic y, input logic bin);
        return (~x & y) | (~(x ^ y) & bin);
    endfunction

    state_t             r_state;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [WIDTH-2:0]   r_sr;
    logic               r_borrow;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
`ifdef SERIAL_SUB_OVF_EN
    logic               r_amsb;
    logic               r_bmsb;
    logic               r_ovf;
`endif

    logic               w_d;
    logic               w_bnext;
    logic [WIDTH-1:0]   w_res;

    // Current subtractor cell and the result as it will look after this bit.
    assign w_d     = sub_bit(r_sa[0], r_sb[0], r_borrow);
    assign w_bnext = sub_borrow(r_sa[0], r_sb[0], r_borrow);
    assign w_res   = {w_d, r_sr};

    // Handshake FSM, operand shifters, borrow and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_sa     <= '0;
            r_sb     <= '0;
            r_sr     <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_amsb   <= 1'b0;
            r_bmsb   <= 1'b0;
            r_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sa     <= a;
                        r_sb     <= b;
                        r_sr     <= '0;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                        r_amsb   <= a[WIDTH-1];
                        r_bmsb   <= b[WIDTH-1];
`endif
                        r_state  <= S_RUN;
                    end else begin
                        r_busy   <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_sa     <= {1'b0, r_sa[WIDTH-1:1]};
                    r_sb     <= {1'b0, r_sb[WIDTH-1:1]};
                    r_sr     <= w_res[WIDTH-1:1];
                    r_borrow <= w_bnext;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_diff  <= w_res;
                        r_bout  <= w_bnext;
`ifdef SERIAL_SUB_OVF_EN
                        // Signed overflow: operands differ in sign and result sign differs from a.
                        r_ovf   <= (r_amsb != r_bmsb) && (w_d != r_amsb);
`endif
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8); ovf checks when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full operation: checks latency, busy length, result and single-cycle done.
    task automatic do_sub(input logic [7:0] ia, input logic [7:0] ib,
                          input logic [7:0] ed, input logic eb, input logic eo,
                          input string tag);
        int lat;
        int bcnt;
        @(negedge clk);
        a = ia; b = ib; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0; bcnt = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        check_val({tag, "_lat"},  lat, WIDTH);
        check_val({tag, "_busy"}, bcnt, WIDTH);
        check_val({tag, "_diff"}, diff, ed);
        check_val({tag, "_bout"}, bout, eb);
        check_val({tag, "_busy_at_done"}, busy, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        check_val({tag, "_ovf"}, ovf, eo);
`else
        if (eo) begin end
`endif
        @(negedge clk);
        check_val({tag, "_done_one"}, done, 1'b0);
    endtask

    initial begin
        int lat;
        int dcnt;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        #1;
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_diff", diff, 8'h00);
        check_val("rst_bout", bout, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic results and edge cases.
        do_sub(8'd5,  8'd3,  8'h02, 1'b0, 1'b0, "t1");
        do_sub(8'd3,  8'd5,  8'hFE, 1'b1, 1'b0, "t2a");
        do_sub(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, "t2b");
        do_sub(8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0, "t2c");

        // start during RUN and during DONE must be ignored.
        @(negedge clk);
        a = 8'h10; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcnt = 0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 3) begin
                a = 8'h00; b = 8'h00; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                dcnt++;
                start = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check_val("t3_done_cnt", dcnt, 1);
        check_val("t3_diff", diff, 8'h0F);
        check_val("t3_bout", bout, 1'b0);
        check_val("t3_busy", busy, 1'b0);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        a = 8'hF0; b = 8'h0F; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("t4_busy", busy, 1'b0);
        check_val("t4_done", done, 1'b0);
        check_val("t4_diff", diff, 8'h00);
        check_val("t4_bout", bout, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        check_val("t4_no_done", dcnt, 0);
        do_sub(8'd9, 8'd4, 8'h05, 1'b0, 1'b0, "t4b");

        // Operand changes during RUN have no effect; diff holds until completion.
        @(negedge clk);
        a = 8'h20; b = 8'h10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            check_val("t5_hold", diff, 8'h05);
            a = 8'($urandom);
            b = 8'($urandom);
            @(negedge clk);
            lat++;
        end
        check_val("t5_lat", lat, WIDTH);
        check_val("t5_diff", diff, 8'h10);
        check_val("t5_bout", bout, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
        do_sub(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "t6a");
        do_sub(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "t6b");
        do_sub(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, "t6c");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
